// File: rtl/timer_bank.sv
// Bank of NCH down-counting timers driven by one shared tick prescaler.
// Define TIMER_BANK_RELOAD_EN to add per-channel reload registers (periodic mode).
module timer_bank #(
  parameter int TICK_DIV = 833333,
  parameter int NCH      = 2,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 4
) (
  input  logic             SYS_CLK,
  input  logic             reset,
  input  logic             pause,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             wr_tgt,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_value,
  output logic [NCH-1:0]   active,
  output logic [NCH-1:0]   expire,
  output logic             tick
);

  localparam int              CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q [NCH];
  logic [WIDTH-1:0] value_d [NCH];
  logic [NCH-1:0]   expire_q, expire_d;
  logic [NCH-1:0]   sel_hit;

`ifdef TIMER_BANK_RELOAD_EN
  logic [WIDTH-1:0] reload_q [NCH];
  logic [WIDTH-1:0] reload_d [NCH];
`endif

  // Prescaler: free-running 0..TICK_DIV-1, frozen while paused.
  always_comb begin
    tick  = (cnt_q == CNT_MAX) && !pause;
    cnt_d = cnt_q;
    if (!pause) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  // Write interface: wr_en is a one-cycle strobe with no ready; every strobe
  // is accepted and lands at the next edge, out-of-range selects match nothing.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sel_hit[i] = wr_en && (wr_sel == SEL_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      value_d[i]  = value_q[i];
      expire_d[i] = 1'b0;
`ifdef TIMER_BANK_RELOAD_EN
      reload_d[i] = (sel_hit[i] && wr_tgt) ? wr_data : reload_q[i];
`endif
      if (sel_hit[i] && !wr_tgt) begin
        value_d[i] = wr_data;
      end else if (tick && (value_q[i] != '0)) begin
        if (value_q[i] == WIDTH'(1)) begin
          expire_d[i] = 1'b1;
`ifdef TIMER_BANK_RELOAD_EN
          // A zero reload register naturally degenerates to one-shot.
          value_d[i]  = reload_q[i];
`else
          value_d[i]  = '0;
`endif
        end else begin
          value_d[i] = value_q[i] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        value_q[i] <= '0;
`ifdef TIMER_BANK_RELOAD_EN
        reload_q[i] <= '0;
`endif
      end
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
      for (int i = 0; i < NCH; i++) begin
        value_q[i] <= value_d[i];
`ifdef TIMER_BANK_RELOAD_EN
        reload_q[i] <= reload_d[i];
`endif
      end
    end
  end

  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NCH; i++) begin
      active[i] = (value_q[i] != '0);
      if (rd_sel == SEL_W'(i)) begin
        rd_value = value_q[i];
      end
    end
  end

  assign expire = expire_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with TICK_DIV=4, two 8-bit channels.
`timescale 1ns/1ps
module tb_timer_bank;
  localparam int TICK_DIV = 4;
  localparam int NCH      = 2;
  localparam int WIDTH    = 8;
  localparam int SEL_W    = 4;

  logic             SYS_CLK = 1'b0;
  logic             reset;
  logic             pause;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic             wr_tgt;
  logic [WIDTH-1:0] wr_data;
  logic [SEL_W-1:0] rd_sel;
  logic [WIDTH-1:0] rd_value;
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   expire;
  logic             tick;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  timer_bank #(
    .TICK_DIV(TICK_DIV), .NCH(NCH), .WIDTH(WIDTH), .SEL_W(SEL_W)
  ) dut (
    .SYS_CLK (SYS_CLK),
    .reset   (reset),
    .pause   (pause),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_tgt  (wr_tgt),
    .wr_data (wr_data),
    .rd_sel  (rd_sel),
    .rd_value(rd_value),
    .active  (active),
    .expire  (expire),
    .tick    (tick)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge SYS_CLK);
      #1;
    end
  endtask

  task automatic write(input logic [SEL_W-1:0] s, input logic tgt, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = s;
    wr_tgt  = tgt;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [SEL_W-1:0] s);
    rd_sel = s;
    #1;
    check(tag, 16'(rd_value));
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; wr_en = 1'b0; wr_tgt = 1'b0;
    wr_sel = '0; wr_data = '0; rd_sel = '0;
    step(3);
    reset = 1'b0;
    #1;
    // Reset state, prescaler phase 0
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    check("rst_tick", 16'(tick));
    check("rst_active", 16'(active));
    check("rst_expire", 16'(expire));
    chk_rd("rst_rd0", 4'd0);
    chk_rd("rst_rd1", 4'd1);

    for (int c = 1; c <= 11; c++) begin
      exp_q.push_back((c % 4 == 3) ? 16'd1 : 16'd0);
      step();
      check("tick_cadence", 16'(tick));
    end

    // One-shot countdown on ch0
    step();
    exp_q.push_back(16'd3); exp_q.push_back(16'b01); exp_q.push_back(16'd0);
    write(4'd0, 1'b0, 8'd3);
    chk_rd("oneshot_3", 4'd0);
    check("oneshot_active", 16'(active));
    check("oneshot_noexp", 16'(expire));
    exp_q.push_back(16'd2);
    step(3);
    chk_rd("oneshot_2", 4'd0);
    exp_q.push_back(16'd1);
    step(4);
    chk_rd("oneshot_1", 4'd0);
    exp_q.push_back(16'd0);
    step(3);
    check("oneshot_preexp", 16'(expire));
    exp_q.push_back(16'd0); exp_q.push_back(16'b01); exp_q.push_back(16'b00);
    step();
    chk_rd("oneshot_0", 4'd0);
    check("oneshot_expire", 16'(expire));
    check("oneshot_inactive", 16'(active));
    exp_q.push_back(16'd0);
    step();
    check("expire_single", 16'(expire));
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    step(3);
    chk_rd("no_underflow", 4'd0);
    check("no_reexpire", 16'(expire));
    step();

    // Write collides with tick on ch0 only
    write(4'd0, 1'b0, 8'd5);
    write(4'd1, 1'b0, 8'd5);
    exp_q.push_back(16'd1);
    check("coll_tick", 16'(tick));
    exp_q.push_back(16'd9); exp_q.push_back(16'd4); exp_q.push_back(16'd0);
    write(4'd0, 1'b0, 8'd9);
    chk_rd("coll_ch0", 4'd0);
    chk_rd("coll_ch1", 4'd1);
    check("coll_noexp", 16'(expire));

    // Pause freezes prescaler and channels
    exp_q.push_back(16'd2);
    write(4'd1, 1'b0, 8'd2);
    chk_rd("pause_pre", 4'd1);
    exp_q.push_back(16'd1);
    step(2);
    check("phase_kept", 16'(tick));
    pause = 1'b1;
    #1;
    exp_q.push_back(16'd0);
    check("pause_gate", 16'(tick));
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(16'd0);
      step();
      check("pause_tick", 16'(tick));
    end
    exp_q.push_back(16'd2); exp_q.push_back(16'd9);
    chk_rd("pause_ch1", 4'd1);
    chk_rd("pause_ch0", 4'd0);
    pause = 1'b0;
    #1;
    exp_q.push_back(16'd1);
    check("pause_resume", 16'(tick));
    exp_q.push_back(16'd1); exp_q.push_back(16'd8);
    step();
    chk_rd("resume_ch1", 4'd1);
    chk_rd("resume_ch0", 4'd0);
    exp_q.push_back(16'd1);
    step(3);
    check("resume_next_tick", 16'(tick));
    exp_q.push_back(16'd0); exp_q.push_back(16'b10); exp_q.push_back(16'b01);
    step();
    chk_rd("ch1_zero", 4'd1);
    check("ch1_expire", 16'(expire));
    check("ch1_inactive", 16'(active));
    exp_q.push_back(16'd0);
    step();
    check("ch1_expire_end", 16'(expire));

    // Out-of-range select, and zero write to an active channel
    exp_q.push_back(16'd0); exp_q.push_back(16'd7);
    exp_q.push_back(16'd0); exp_q.push_back(16'b01);
    write(4'd2, 1'b0, 8'h55);
    chk_rd("oob_rd", 4'd2);
    chk_rd("oob_ch0", 4'd0);
    chk_rd("oob_ch1", 4'd1);
    check("oob_active", 16'(active));
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    write(4'd0, 1'b0, 8'd0);
    chk_rd("zero_wr_ch0", 4'd0);
    check("zero_wr_active", 16'(active));
    check("zero_wr_noexp", 16'(expire));
    exp_q.push_back(16'd0);
    step();
    check("zero_wr_noexp_tick", 16'(expire));

    // Reload register behaviour
    write(4'd0, 1'b1, 8'd2);
    exp_q.push_back(16'd1);
    write(4'd0, 1'b0, 8'd1);
    chk_rd("reload_pre", 4'd0);
`ifdef TIMER_BANK_RELOAD_EN
    exp_q.push_back(16'd2); exp_q.push_back(16'b01); exp_q.push_back(16'b01);
`else
    exp_q.push_back(16'd0); exp_q.push_back(16'b01); exp_q.push_back(16'b00);
`endif
    step(2);
    chk_rd("reload_val", 4'd0);
    check("reload_expire", 16'(expire));
    check("reload_active", 16'(active));
`ifdef TIMER_BANK_RELOAD_EN
    exp_q.push_back(16'd1); exp_q.push_back(16'd0);
`else
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
`endif
    step(4);
    chk_rd("reload_val2", 4'd0);
    check("reload_expire2", 16'(expire));
`ifdef TIMER_BANK_RELOAD_EN
    exp_q.push_back(16'd2); exp_q.push_back(16'b01);
`else
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
`endif
    step(4);
    chk_rd("reload_val3", 4'd0);
    check("reload_expire3", 16'(expire));

    // Asynchronous reset mid-count
    exp_q.push_back(16'd3);
    write(4'd1, 1'b0, 8'd3);
    chk_rd("prerst_ch1", 4'd1);
    step();
    reset = 1'b1;
    #1;
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    chk_rd("midrst_ch1", 4'd1);
    check("midrst_active", 16'(active));
    check("midrst_tick", 16'(tick));
    exp_q.push_back(16'd0);
    step();
    check("midrst_expire", 16'(expire));
    reset = 1'b0;
    step();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
